div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 159 +++++++++++++++
 tb/tb_div_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider controller (FREE/DIVZERO/ON/END).
// Signed division is built only when DIV_SIGNED_EN is defined; otherwise signed_i is ignored.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        busy_q;
    logic        ready_q;
    logic [63:0] result_q;

    logic [31:0] dividend_abs_d;
    logic [31:0] divisor_abs_d;
    logic [32:0] diff_d;
    logic [64:0] work_step_d;
    logic [31:0] quot_d;
    logic [31:0] rem_d;

`ifdef DIV_SIGNED_EN
    logic        op1_neg_d;
    logic        op2_neg_d;
    logic        neg_quot_q;
    logic        neg_rem_q;
`else
    logic        unused_signed_s;
    assign unused_signed_s = signed_i;
`endif

    // Operand magnitudes, one restoring step, and the sign-corrected final result.
    always_comb begin
`ifdef DIV_SIGNED_EN
        op1_neg_d      = signed_i & opdata1_i[31];
        op2_neg_d      = signed_i & opdata2_i[31];
        dividend_abs_d = op1_neg_d ? (~opdata1_i + 32'd1) : opdata1_i;
        divisor_abs_d  = op2_neg_d ? (~opdata2_i + 32'd1) : opdata2_i;
        quot_d         = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem_d          = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];
`else
        dividend_abs_d = opdata1_i;
        divisor_abs_d  = opdata2_i;
        quot_d         = work_q[31:0];
        rem_d          = work_q[64:33];
`endif
        diff_d      = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        work_step_d = diff_d[32] ? {work_q[63:0], 1'b0}
                                 : {diff_d[31:0], work_q[31:0], 1'b1};
    end

    // Controller FSM with registered busy/ready/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= 64'd0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start_i && !annul_i) begin
                        work_q    <= {32'd0, dividend_abs_d, 1'b0};
                        divisor_q <= divisor_abs_d;
                        cnt_q     <= 6'd0;
                        busy_q    <= 1'b1;
`ifdef DIV_SIGNED_EN
                        neg_quot_q <= op1_neg_d ^ op2_neg_d;
                        neg_rem_q  <= op1_neg_d;
`endif
                        if (opdata2_i == 32'd0) begin
                            state_q <= DIVZERO;
                        end else begin
                            state_q <= ON;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                DIVZERO: begin
                    busy_q   <= 1'b0;
                    result_q <= 64'd0;
                    if (annul_i) begin
                        state_q <= FREE;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= END;
                        ready_q <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_q <= FREE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= 6'd0;
                        work_q  <= 65'd0;
                    end else if (cnt_q != 6'd32) begin
                        work_q <= work_step_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        state_q  <= END;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        result_q <= {rem_d, quot_d};
                    end
                end
                END: begin
                    busy_q <= 1'b0;
                    if (annul_i || !start_i) begin
                        state_q  <= FREE;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                        cnt_q    <= 6'd0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= FREE;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    cnt_q    <= 6'd0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed plus random bench for div_ctrl with a result scoreboard.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        busy_o;
    logic        ready_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference quotient/remainder using native division on magnitudes.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ua, ub, q, r;
        logic na, nb;
        if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
        na = sgn & a[31];
        nb = sgn & b[31];
`else
        na = 1'b0;
        nb = 1'b0;
`endif
        ua = na ? (32'd0 - a) : a;
        ub = nb ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int exp_busy, input string tag);
        int busy_n;
        logic [63:0] e;
        logic [63:0] got;
        sb_q.push_back(exp);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        busy_n    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom_range(0, 1));
            if (ready_o === 1'b1) break;
            if (busy_o === 1'b1) busy_n++;
        end
        chk({tag, " ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        e   = sb_q.pop_front();
        got = result_o;
        chk({tag, " result"}, got, e);
        @(negedge clk);
        chk({tag, " hold_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, " hold_result"}, result_o, e);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, " free_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, " free_result"}, result_o, 64'd0);
        chk({tag, " free_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        logic        seen_ready;
        logic [31:0] ra, rb;
        logic        rs;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst busy", {63'd0, busy_o}, 64'd0);
        chk("rst ready", {63'd0, ready_o}, 64'd0);
        chk("rst result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "u100_7");
`ifdef DIV_SIGNED_EN
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s-7_2");
        do_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, "s7_-2");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "smin_-1");
`else
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'd1, 32'h7FFFFFFC}, 33, "s-7_2");
        do_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd7, 32'd0}, 33, "s7_-2");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, 33, "smin_-1");
`endif
        do_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "umax_1");
        do_div(32'd5, 32'd0, 1'b0, 64'd0, 1, "u5_0");

        // Annul mid-divide at cnt=10.
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        seen_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen_ready = 1'b1;
        end
        chk("annul busy_before", {63'd0, busy_o}, 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul busy", {63'd0, busy_o}, 64'd0);
        chk("annul ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) seen_ready = 1'b1;
        end
        chk("annul no_ready", {63'd0, seen_ready}, 64'd0);
        do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "u9_3");

        // Asynchronous reset at cnt=20, then start on first edge after release.
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        for (int i = 0; i < 21; i++) @(negedge clk);
        chk("rst20 busy_before", {63'd0, busy_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst20 busy", {63'd0, busy_o}, 64'd0);
        chk("rst20 ready", {63'd0, ready_o}, 64'd0);
        chk("rst20 result", result_o, 64'd0);
        rst = 1'b0;
        do_div(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 33, "u1000_10");

        // Start with annul in FREE is ignored.
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("free_annul busy", {63'd0, busy_o}, 64'd0);
        end
        chk("free_annul ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

        // Annul while in END discards the result.
        start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
        repeat (2) @(negedge clk);
        chk("end_annul ready_before", {63'd0, ready_o}, 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        chk("end_annul ready", {63'd0, ready_o}, 64'd0);
        chk("end_annul result", result_o, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rs = 1'($urandom_range(0, 1));
            do_div(ra, rb, rs, model(ra, rb, rs), (rb == 32'd0) ? 1 : 33, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
